// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receiver: output code constants, the
// decoder FSM state type and the symbol-pattern to character lookup.
// Symbol patterns are stored with the first symbol in the most significant
// used bit (1 = dash, 0 = dot). Unused upper bits are zero.
package morse_pkg;

  localparam int SYM_W = 5;  // widest pattern the lookup understands
  localparam int LEN_W = 3;  // holds a symbol count of 0..SYM_W

  localparam logic [5:0] CODE_SPACE = 6'd36;
  localparam logic [5:0] CODE_ERR   = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_WAIT_WORD
  } morse_state_t;

  // Map {length, pattern} to a character code; anything unknown is CODE_ERR.
  function automatic logic [5:0] morse_lookup(input logic [LEN_W-1:0] len,
                                              input logic [SYM_W-1:0] pattern);
    logic [5:0] code;
    code = CODE_ERR;
    case ({len, pattern})
      8'b001_00000: code = 6'd4;   // E .
      8'b001_00001: code = 6'd19;  // T -
      8'b010_00001: code = 6'd0;   // A .-
      8'b010_00000: code = 6'd8;   // I ..
      8'b010_00011: code = 6'd12;  // M --
      8'b010_00010: code = 6'd13;  // N -.
      8'b011_00100: code = 6'd3;   // D -..
      8'b011_00110: code = 6'd6;   // G --.
      8'b011_00101: code = 6'd10;  // K -.-
      8'b011_00111: code = 6'd14;  // O ---
      8'b011_00010: code = 6'd17;  // R .-.
      8'b011_00000: code = 6'd18;  // S ...
      8'b011_00001: code = 6'd20;  // U ..-
      8'b011_00011: code = 6'd22;  // W .--
      8'b100_01000: code = 6'd1;   // B -...
      8'b100_01010: code = 6'd2;   // C -.-.
      8'b100_00010: code = 6'd5;   // F ..-.
      8'b100_00000: code = 6'd7;   // H ....
      8'b100_00111: code = 6'd9;   // J .---
      8'b100_00100: code = 6'd11;  // L .-..
      8'b100_00110: code = 6'd15;  // P .--.
      8'b100_01101: code = 6'd16;  // Q --.-
      8'b100_00001: code = 6'd21;  // V ...-
      8'b100_01001: code = 6'd23;  // X -..-
      8'b100_01011: code = 6'd24;  // Y -.--
      8'b100_01100: code = 6'd25;  // Z --..
      8'b101_11111: code = 6'd26;  // 0 -----
      8'b101_01111: code = 6'd27;  // 1 .----
      8'b101_00111: code = 6'd28;  // 2 ..---
      8'b101_00011: code = 6'd29;  // 3 ...--
      8'b101_00001: code = 6'd30;  // 4 ....-
      8'b101_00000: code = 6'd31;  // 5 .....
      8'b101_10000: code = 6'd32;  // 6 -....
      8'b101_11000: code = 6'd33;  // 7 --...
      8'b101_11100: code = 6'd34;  // 8 ---..
      8'b101_11110: code = 6'd35;  // 9 ----.
      default:      code = CODE_ERR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Time-unit divider: a down-counter that pulses tick for one clk at zero and
// reloads with (BASE_DIV << spec) - 1. spec is only looked at on reload so a
// rate change never produces a truncated tick period.
module morse_tick_gen #(
  parameter int BASE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] spec,
  output logic       tick
);

  // Room for BASE_DIV shifted by the largest spec value (7).
  localparam int DIV_W = $clog2(BASE_DIV) + 8;

  logic [DIV_W-1:0] div_cnt;

  // Count down, reloading from the current rate select at zero.
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its sources, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == '0) begin
      div_cnt <= (DIV_W'(BASE_DIV) << spec) - DIV_W'(1);
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  assign tick = (div_cnt == '0);

endmodule

// File: rtl/morse_decoder_param.sv
// Parametrised Morse receiver: synchroniser, glitch filter, tick-based mark
// and space timing, symbol assembly and a valid/ack output register with
// sticky overrun. Optional macro MORSE_WORD_SPACE_EN makes a word gap emit
// the space code (36) once; without it word gaps are silent.
module morse_decoder_param
  import morse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int BASE_DIV    = 8,
  parameter int DOT_MAX     = 2,
  parameter int CHAR_GAP    = 3,
  parameter int WORD_GAP    = 7,
  parameter int MAX_SYM     = 5,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       noisy_in,
  input  logic [2:0] spec,
  input  logic       char_ack,
  output logic [5:0] char_out,
  output logic       char_valid,
  output logic       char_err,
  output logic       overrun
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] DUR_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [FC_W-1:0]        filt_cnt;
  logic                   filt, filt_q;
  logic                   rise, fall;
  logic                   tick;
  logic [CNT_W-1:0]       dur;
  logic                   dash, char_reach, word_reach;
  morse_state_t           state;
  logic [SYM_W-1:0]       sym_pat;
  logic [LEN_W-1:0]       sym_len;
  logic                   sym_err;
  logic                   emit;
  logic [5:0]             emit_code;

  morse_tick_gen #(.BASE_DIV(BASE_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .spec (spec),
    .tick (tick)
  );

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= SYNC_STAGES'({sync_q, noisy_in});
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Flip the filtered level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      filt     <= 1'b0;
    end else if (sync_out == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt     <= sync_out;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FC_W'(1);
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) filt_q <= 1'b0;
    else      filt_q <= filt;
  end

  assign rise = filt & ~filt_q;
  assign fall = ~filt & filt_q;

  // Duration in ticks since the last filtered edge; the edge cycle itself
  // counts so a mark of N tick periods measures exactly N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur <= '0;
    end else if (rise || fall) begin
      dur <= CNT_W'(tick);
    end else if (tick && dur != DUR_MAX) begin
      dur <= dur + CNT_W'(1);
    end
  end

  assign dash       = (dur > CNT_W'(DOT_MAX));
  assign char_reach = tick && (dur == CNT_W'(CHAR_GAP - 1));
  assign word_reach = tick && (dur == CNT_W'(WORD_GAP - 1));

  // Symbol assembly and gap tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      sym_pat <= '0;
      sym_len <= '0;
      sym_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) state <= ST_MARK;
        end
        ST_MARK: begin
          if (fall) begin
            state <= ST_GAP;
            if (sym_len == LEN_W'(MAX_SYM)) begin
              sym_err <= 1'b1;
            end else begin
              sym_pat <= {sym_pat[SYM_W-2:0], dash};
              sym_len <= sym_len + LEN_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (rise) begin
            state <= ST_MARK;
          end else if (char_reach) begin
            state   <= ST_WAIT_WORD;
            sym_pat <= '0;
            sym_len <= '0;
            sym_err <= 1'b0;
          end
        end
        ST_WAIT_WORD: begin
          if (rise)            state <= ST_MARK;
          else if (word_reach) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decide whether this cycle produces a character and which one.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    emit      = 1'b0;
    emit_code = CODE_ERR;
    case (state)
      ST_GAP: begin
        if (!rise && char_reach) begin
          emit      = 1'b1;
          emit_code = sym_err ? CODE_ERR : morse_lookup(sym_len, sym_pat);
        end
      end
`ifdef MORSE_WORD_SPACE_EN
      ST_WAIT_WORD: begin
        if (!rise && word_reach) begin
          emit      = 1'b1;
          emit_code = CODE_SPACE;
        end
      end
`endif
      default: ;
    endcase
  end

  // Output holding register with valid/ack handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_out   <= '0;
      char_valid <= 1'b0;
      char_err   <= 1'b0;
      overrun    <= 1'b0;
    end else if (emit && (!char_valid || char_ack)) begin
      char_out   <= emit_code;
      char_err   <= (emit_code == CODE_ERR);
      char_valid <= 1'b1;
    end else begin
      if (emit)                  overrun    <= 1'b1;
      if (char_valid && char_ack) char_valid <= 1'b0;
    end
  end

endmodule
